// File: rtl/regs_write_sched.sv
// regs_write_sched: arbitrates ALU, memory and PC-link requests onto the single
// register-bank write port, splitting 32-bit immediates into two half-word writes.
module regs_write_sched #(
   parameter logic [3:0] LINK_REG  = 4'd15,
   parameter logic [2:0] IDLE_CTRL = 3'b111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [3:0]  a_sel,
   input  logic [31:0] a_data,
   input  logic        a_split,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [3:0]  m_sel,
   input  logic [31:0] m_data,
   input  logic        m_split,
   input  logic        link_valid,
   output logic        link_ready,
   input  logic [31:0] link_pc,
   output logic [3:0]  wr_sel,
   output logic [31:0] wr_data,
   output logic [31:0] wr_pc,
   output logic [2:0]  wr_ctrl,
   output logic        busy
);
   typedef enum logic {IDLE, SPLIT_HI} state_t;
   state_t      state_q, state_d;
   logic        rr_last_q, rr_last_d;
   logic [15:0] hi_q, hi_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] data_q, data_d, pc_q, pc_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        idle, arb, a_acc, m_acc, wr_acc, split;
   logic [3:0]  sel_in;
   logic [31:0] data_in;

   // rr_last_q: 1 = memory granted last, so ALU wins the next tie
   assign idle       = rst_n && state_q == IDLE;
   assign link_ready = idle && link_valid;
   assign arb        = idle && !link_valid;
   assign a_ready    = arb && a_valid && (!m_valid || rr_last_q);
   assign m_ready    = arb && m_valid && (!a_valid || !rr_last_q);
   assign a_acc      = a_valid && a_ready;
   assign m_acc      = m_valid && m_ready;
   assign wr_acc     = a_acc || m_acc;
   assign sel_in     = a_acc ? a_sel : m_sel;
   assign data_in    = a_acc ? a_data : m_data;
   assign split      = a_acc ? a_split : m_split;
   assign rr_last_d  = a_acc ? 1'b0 : m_acc ? 1'b1 : rr_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         hi_q      <= '0;
         sel_q     <= '0;
         data_q    <= '0;
         pc_q      <= '0;
         ctrl_q    <= IDLE_CTRL;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         hi_q      <= hi_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         pc_q      <= pc_d;
         ctrl_q    <= ctrl_d;
      end
   end

   always_comb state_d = (state_q == IDLE && wr_acc && split) ? SPLIT_HI : IDLE;

   always_comb begin
      ctrl_d = IDLE_CTRL;
      sel_d  = sel_q;
      data_d = data_q;
      pc_d   = pc_q;
      hi_d   = hi_q;
      if (state_q == SPLIT_HI) begin
         ctrl_d = 3'b010;
         data_d = {16'h0, hi_q};
      end else if (link_ready) begin
         ctrl_d = 3'b011;
         pc_d   = link_pc;
         sel_d  = LINK_REG;
      end else if (wr_acc) begin
         ctrl_d = split ? 3'b001 : 3'b000;
         sel_d  = sel_in;
         data_d = split ? {16'h0, data_in[15:0]} : data_in;
         hi_d   = data_in[31:16];
      end
   end

   assign wr_sel  = sel_q;
   assign wr_data = data_q;
   assign wr_pc   = pc_q;
   assign wr_ctrl = ctrl_q;
   assign busy    = state_q == SPLIT_HI;
endmodule
